// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word reads, queues returned instructions in order and
// hands them to decode over valid/ready; redirects flush the queue and discard stale reads.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        f_valid,
    input  logic        f_ready,
    output logic [31:0] f_instr,
    output logic [31:0] f_pc,
    output logic [31:0] f_pc_plus4,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5
);
    localparam int PW       = $clog2(DEPTH);
    localparam int CW       = $clog2(DEPTH) + 1;
    localparam int DW       = CW + 1;
    localparam int DISC_MAX = (1 << DW) - 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [DW-1:0] discard;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];

    logic [CW:0]   occupancy;
    logic [DW:0]   outstanding;
    logic [DW-1:0] disc_next;
    logic [31:0]   target;
    logic          accept;
    logic          push;
    logic          drop;
    logic          pop;

    // Decrement that floors at zero; a redirect-cycle response always retires one outstanding read.
    function automatic logic [DW-1:0] dec_floor0(input logic [DW-1:0] v, input logic en);
        return (en && v != '0) ? v - DW'(1) : v;
    endfunction

    assign occupancy   = {1'b0, count} + {1'b0, inflight};
    assign outstanding = {1'b0, discard} + (DW+1)'(inflight);

    // The outstanding cap keeps the discard counter from wrapping if redirects outpace responses.
    assign imem_req  = !reset && !redirect && (occupancy < (CW+1)'(DEPTH))
                       && (outstanding < (DW+1)'(DISC_MAX));
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ready;
    assign push      = imem_rvalid && !redirect && (discard == '0) && (inflight != '0);
    assign drop      = imem_rvalid && !redirect && (discard != '0);
    assign f_valid   = !reset && (count != '0);
    assign pop       = f_valid && f_ready && !redirect;
    assign target    = redirect_pc & 32'hFFFF_FFFC;
    assign disc_next = dec_floor0(discard + DW'(inflight), imem_rvalid);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (redirect) begin
            fetch_pc <= target;
            resp_pc  <= target;
            count    <= '0;
            inflight <= '0;
            discard  <= disc_next;
            head     <= tail;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
                tail    <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (drop) begin
                discard <= discard - DW'(1);
            end
            inflight <= inflight + CW'(accept) - CW'(push);
            count    <= count + CW'(push) - CW'(pop);
        end
    end

    // Queue storage carries no reset; entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            q_instr[tail] <= imem_rdata;
            q_pc[tail]    <= resp_pc;
        end
    end

    assign f_instr    = q_instr[head];
    assign f_pc       = q_pc[head];
    assign f_pc_plus4 = f_pc + 32'd4;
    assign op         = f_instr[6:0];
    assign funct3     = f_instr[14:12];
    assign funct7b5   = f_instr[30];

    stray_rvalid: assert property (@(posedge clk) disable iff (reset)
        !(imem_rvalid && inflight == '0 && discard == '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, corner sequences and a randomized run checked against an
// epoch-tagged transaction model of the instruction stream.
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, imem_req, imem_ready, imem_rvalid, redirect, f_valid, f_ready, funct7b5;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, f_instr, f_pc, f_pc_plus4;
    logic [6:0]  op;
    logic [2:0]  funct3;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .f_valid(f_valid), .f_ready(f_ready),
        .f_instr(f_instr), .f_pc(f_pc), .f_pc_plus4(f_pc_plus4), .op(op), .funct3(funct3),
        .funct7b5(funct7b5)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] mpc; int due; int ep; } rd_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct {
        logic [31:0] rpc; logic [31:0] instr; logic [31:0] addr; logic [31:0] next;
        logic [31:0] plus4; logic [6:0] op; logic [2:0] f3; logic f7;
    } vec_t;

    rd_t         mq[$];
    ent_t        exp_q[$];
    vec_t        vt[5];
    int          epoch, cyc, last_due, n_chk, n_pass, ready_pct, lat_min, lat_max;
    logic [31:0] exp_fetch, ovr_addr, ovr_val, held_pc;
    logic        ovr_en;
    logic        s_req, s_fvalid, s_f7;
    logic [31:0] s_addr, s_fpc, s_plus4, s_instr;
    logic [6:0]  s_op;
    logic [2:0]  s_f3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h at cycle %0d", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ovr_en && a == ovr_addr) return ovr_val;
        return {a[7:0], a[31:8]} ^ 32'h9E37_79B9;
    endfunction

    function automatic int pend_cur();
        int k = 0;
        foreach (mq[i]) if (mq[i].ep == epoch) k++;
        return k;
    endfunction

    // One clock: drive memory, sample outputs, compare against the model, then advance the model.
    task automatic tick();
        rd_t  r;
        ent_t e;
        logic resp, exp_req;
        int   lat;
        imem_ready  = (int'($urandom_range(99)) < ready_pct);
        resp        = (mq.size() != 0) && (mq[0].due <= cyc);
        imem_rvalid = resp;
        imem_rdata  = resp ? mem_word(mq[0].addr) : $urandom();
        #1;
        s_req = imem_req; s_addr = imem_addr; s_fvalid = f_valid; s_fpc = f_pc;
        s_plus4 = f_pc_plus4; s_instr = f_instr; s_op = op; s_f3 = funct3; s_f7 = funct7b5;
        chk("f_valid", 32'(s_fvalid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("f_pc", s_fpc, exp_q[0].pc);
            chk("f_instr", s_instr, exp_q[0].instr);
            chk("f_pc_plus4", s_plus4, exp_q[0].pc + 32'd4);
            chk("op", 32'(s_op), 32'(exp_q[0].instr[6:0]));
            chk("funct3", 32'(s_f3), 32'(exp_q[0].instr[14:12]));
            chk("funct7b5", 32'(s_f7), 32'(exp_q[0].instr[30]));
        end
        exp_req = !reset && !redirect && (exp_q.size() + pend_cur() < DEPTH);
        chk("imem_req", 32'(s_req), 32'(exp_req));
        if (!reset && s_req && imem_ready) chk("imem_addr", s_addr, exp_fetch);

        if (resp) r = mq.pop_front();
        if (reset) begin
            mq.delete(); exp_q.delete(); exp_fetch = RESET_PC; last_due = cyc;
        end else if (redirect) begin
            epoch++; exp_q.delete(); exp_fetch = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (exp_q.size() != 0 && f_ready) exp_q.delete(0);
            if (resp && r.ep == epoch) begin
                e.pc = r.mpc; e.instr = mem_word(r.mpc); exp_q.push_back(e);
            end
        end
        if (!reset && s_req && imem_ready) begin
            lat   = int'($urandom_range(lat_max, lat_min));
            r.addr = s_addr; r.mpc = exp_fetch; r.ep = epoch;
            r.due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = r.due;
            mq.push_back(r);
            exp_fetch += 32'd4;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        ready_pct = 0;
        while (mq.size() != 0 && n < 40) begin tick(); n++; end
        chk("drain_done", 32'(mq.size()), 32'd0);
        ready_pct = 100;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] pc);
        int n = 0;
        tick();
        while (!s_fvalid && n < 30) begin tick(); n++; end
        chk({name, "_valid"}, 32'(s_fvalid), 32'd1);
        chk(name, s_fpc, pc);
    endtask

    initial begin
        int n;
        n_chk = 0; n_pass = 0; epoch = 0; cyc = 0; last_due = -1;
        ready_pct = 100; lat_min = 1; lat_max = 1;
        ovr_en = 1'b1; ovr_addr = RESET_PC; ovr_val = 32'h40B5_0533;
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; f_ready = 1'b1;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; exp_fetch = RESET_PC;

        vt[0] = '{32'h0000_0203, 32'h40B5_0533, 32'h0000_0200, 32'h0000_0204, 32'h0000_0204, 7'h33, 3'd0, 1'b1};
        vt[1] = '{32'hFFFF_FFFC, 32'h00A0_0093, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 7'h13, 3'd0, 1'b0};
        vt[2] = '{32'h0000_1001, 32'h0062_A023, 32'h0000_1000, 32'h0000_1004, 32'h0000_1004, 7'h23, 3'd2, 1'b0};
        vt[3] = '{32'h8000_0002, 32'h4000_D093, 32'h8000_0000, 32'h8000_0004, 32'h8000_0004, 7'h13, 3'd5, 1'b1};
        vt[4] = '{32'h7FFF_FFFF, 32'h0000_6063, 32'h7FFF_FFFC, 32'h8000_0000, 32'h8000_0000, 7'h63, 3'd6, 1'b0};

        @(negedge clk);
        repeat (3) begin
            tick();
            chk("reset_req", 32'(s_req), 32'd0);
            chk("reset_fvalid", 32'(s_fvalid), 32'd0);
        end

        // Reset release with single-cycle memory: first instruction visible on the third cycle.
        reset = 1'b0;
        tick();
        chk("t1_req", 32'(s_req), 32'd1);
        chk("t1_addr", s_addr, RESET_PC);
        tick();
        chk("t1_c2_fvalid", 32'(s_fvalid), 32'd0);
        tick();
        chk("t1_c3_fvalid", 32'(s_fvalid), 32'd1);
        chk("t1_c3_pc", s_fpc, 32'h0);
        chk("t1_op", 32'(s_op), 32'h33);
        chk("t1_funct3", 32'(s_f3), 32'd0);
        chk("t1_funct7b5", 32'(s_f7), 32'd1);
        repeat (8) tick();

        // Decode stall: queue fills, requests stop, head holds.
        f_ready = 1'b0;
        tick();
        held_pc = s_fpc;
        repeat (10) tick();
        chk("t2_req_dropped", 32'(s_req), 32'd0);
        chk("t2_fvalid_held", 32'(s_fvalid), 32'd1);
        chk("t2_pc_stable", s_fpc, held_pc);
        f_ready = 1'b1;
        repeat (10) tick();

        // Redirect with one queued entry and two reads in flight.
        drain();
        lat_min = 2; lat_max = 2; f_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h40; tick(); redirect = 1'b0;
        n = 0;
        while (!(exp_q.size() == 1 && pend_cur() == 2) && n < 50) begin tick(); n++; end
        chk("t3_setup", 32'(n < 50), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h100; tick(); redirect = 1'b0; f_ready = 1'b1;
        wait_valid("t3_first_pc", 32'h100);

        // Redirect coinciding with a response and a ready decode stage.
        lat_min = 1; lat_max = 1; ready_pct = 100;
        repeat (6) tick();
        n = 0;
        while (!(exp_q.size() != 0 && mq.size() != 0 && mq[0].due <= cyc) && n < 30) begin tick(); n++; end
        chk("t4_setup", 32'(n < 30), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h300; tick(); redirect = 1'b0;
        chk("t4_no_req_on_redirect", 32'(s_req), 32'd0);
        wait_valid("t4_first_pc", 32'h300);

        // Back-to-back redirects: the later target wins.
        redirect = 1'b1; redirect_pc = 32'h500; tick();
        redirect_pc = 32'h604; tick(); redirect = 1'b0;
        wait_valid("t4b_last_wins", 32'h604);

        // Vector table: target alignment, wrap at the top of memory, decode field extraction.
        for (int i = 0; i < 5; i++) begin
            drain();
            ovr_addr = vt[i].addr; ovr_val = vt[i].instr; f_ready = 1'b0;
            redirect = 1'b1; redirect_pc = vt[i].rpc; tick(); redirect = 1'b0;
            tick();
            chk($sformatf("vec%0d_req", i), 32'(s_req), 32'd1);
            chk($sformatf("vec%0d_addr", i), s_addr, vt[i].addr);
            tick();
            chk($sformatf("vec%0d_next_addr", i), s_addr, vt[i].next);
            tick();
            chk($sformatf("vec%0d_fvalid", i), 32'(s_fvalid), 32'd1);
            chk($sformatf("vec%0d_pc", i), s_fpc, vt[i].addr);
            chk($sformatf("vec%0d_instr", i), s_instr, vt[i].instr);
            chk($sformatf("vec%0d_plus4", i), s_plus4, vt[i].plus4);
            chk($sformatf("vec%0d_op", i), 32'(s_op), 32'(vt[i].op));
            chk($sformatf("vec%0d_funct3", i), 32'(s_f3), 32'(vt[i].f3));
            chk($sformatf("vec%0d_funct7b5", i), 32'(s_f7), 32'(vt[i].f7));
            f_ready = 1'b1;
        end

        // Randomized traffic: memory stalls, variable latency, decode back-pressure, redirects.
        ovr_en = 1'b0; ready_pct = 50; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            f_ready     = (int'($urandom_range(99)) < 70);
            redirect    = (int'($urandom_range(99)) < 4);
            redirect_pc = $urandom();
            tick();
        end
        redirect = 1'b0; f_ready = 1'b1; ready_pct = 100;
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
